serial_twos_complement: RTL
===========================

# serial_twos_complement

Parametrised, bit-serial two's complement unit: negates or takes the absolute value of a WIDTH-bit signed operand, one bit per clock, LSB first, using the invert-and-add-one carry chain from the 8-bit combinational negator, spread over time. Operands are accepted through a start/busy/done handshake. An overflow flag is raised for the most-negative input. Sits between register-file/switch inputs and display or ALU consumers that can tolerate multi-cycle latency in exchange for a single-bit datapath.

## Interface
- WIDTH, 8: operand/result width in bits; legal range 2..32.
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- start  in  1  request; sampled only in IDLE.
- mode  in  1  0 = negate (Y = -A), 1 = absolute value (Y = |A|); sampled with start.
- A  in  WIDTH  signed operand; sampled with start.
- busy  out  1  high in SHIFT and DONE.
- done  out  1  one-cycle pulse when Y/ovf are updated.
- Y  out  WIDTH  result register; holds until next completion.
- ovf  out  1  set when A = 1 followed by WIDTH-1 zeros and the operation negates it; holds with Y.

## Operation
- States: IDLE, SHIFT, DONE. Reset: state IDLE, busy=0, done=0, Y=0, ovf=0, counter=0, carry=1.
- IDLE: if start=1, latch A into operand shift register, latch mode, compute inv = (mode==0) | A[WIDTH-1], clear counter, carry=1 → SHIFT. start=0 → stay.
- SHIFT, per cycle, with b = current operand LSB: if inv, s = ~b XOR carry, carry_next = ~b AND carry; else s = b, carry unchanged. s shifts into Y-staging register MSB side; operand shifts right; counter increments. After bit WIDTH-1 → DONE.
- Overflow: ovf_next = inv AND (A == 1 followed by WIDTH-1 zeros), evaluated on latched operand; final carry-out discarded (negating 0 gives 0, ovf=0).
- DONE: Y and ovf loaded from staging in the transition into DONE; done=1 for this one cycle; → IDLE unconditionally.
- start while busy: ignored, no queueing; A/mode changes during busy have no effect.
- Reset mid-operation: abandons operation at the next edge; all outputs return to reset values; no done pulse.

## Timing
- start sampled high at edge E → SHIFT processes bits at edges E+1..E+WIDTH → Y, ovf updated and state=DONE at edge E+WIDTH; done=1 during the following cycle; IDLE after edge E+WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles; start held high continuously is accepted on the first IDLE cycle after DONE.
- busy rises the cycle after the accepting edge, falls together with done.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- SERIAL_TC_SATURATE_EN defined: on overflow, Y = 0 followed by WIDTH-1 ones (most-positive value), ovf=1.
- Undefined: on overflow, Y wraps to 1 followed by WIDTH-1 zeros (same as input), ovf=1. All non-overflow results are identical in both builds.

## Test plan
- WIDTH=8, negate A=0x05 → Y=0xFB, ovf=0, done pulse exactly 8 cycles after the start edge, busy high for 9 cycles.
- Abs A=0x85 → Y=0x7B; abs A=0x23 → Y=0x23 (pass-through, same latency); negate A=0x00 → Y=0x00, ovf=0.
- Negate A=0x80 and abs A=0x80 → ovf=1, Y=0x80 without macro, Y=0x7F with SERIAL_TC_SATURATE_EN.
- start pulsed and A changed every cycle during busy → ignored; Y reflects only the first accepted operand, exactly one done pulse.
- reset asserted at SHIFT cycle 4 → next cycle busy=0, Y=0, ovf=0, no done; new start afterward completes normally.
- WIDTH=16 (and WIDTH=2): negate 0x1234 → 0xEDCC, latency 16; WIDTH=2 negate 2'b01 → 2'b11, negate 2'b10 → ovf=1.

Source files
------------

// File: rtl/serial_twos_complement_if.sv
// rtl/serial_twos_complement_if.sv - start/busy/done handshake and operand/result bundle for serial_twos_complement
interface serial_twos_complement_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] A;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Y;
    logic             ovf;

    modport master (
        output start, mode, A,
        input  busy, done, Y, ovf
    );

    modport slave (
        input  start, mode, A,
        output busy, done, Y, ovf
    );
endinterface

// File: rtl/serial_twos_complement.sv
// rtl/serial_twos_complement.sv - bit-serial negate / absolute value, LSB first; optional SERIAL_TC_SATURATE_EN
module serial_twos_complement #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    serial_twos_complement_if.slave bus
);
    localparam int               CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST_BIT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] stage;
    logic [WIDTH-1:0] y_q;
    logic [CW-1:0]    cnt;
    logic             inv;
    logic             carry;
    logic             ovf_pend;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;
    logic             bit_s;
    logic             carry_nx;
    logic [WIDTH-1:0] stage_nx;
    logic [WIDTH-1:0] result;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: accept in IDLE, walk WIDTH bits, one DONE cycle, back to IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = SHIFT;
            SHIFT:   if (cnt == LAST_BIT) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // One step of the invert-and-add-one chain on the current operand LSB.
    always_comb begin
        bit_s    = opnd[0];
        carry_nx = carry;
        if (inv) begin
            bit_s    = ~opnd[0] ^ carry;
            carry_nx = ~opnd[0] & carry;
        end
        stage_nx = {bit_s, stage[WIDTH-1:1]};
`ifdef SERIAL_TC_SATURATE_EN
        result   = ovf_pend ? ~MOST_NEG : stage_nx;
`else
        result   = stage_nx;
`endif
    end

    // Datapath: latch operand on accept, shift while in SHIFT, publish on the last bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            opnd     <= '0;
            stage    <= '0;
            y_q      <= '0;
            cnt      <= '0;
            inv      <= 1'b0;
            carry    <= 1'b1;
            ovf_pend <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            busy_q <= (state_nx != IDLE);
            done_q <= (state_nx == DONE);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        opnd     <= bus.A;
                        inv      <= ~bus.mode | bus.A[WIDTH-1];
                        // Negating the most-negative value cannot be represented.
                        ovf_pend <= (bus.A == MOST_NEG) & (~bus.mode | bus.A[WIDTH-1]);
                        cnt      <= '0;
                        carry    <= 1'b1;
                    end
                end
                SHIFT: begin
                    opnd  <= opnd >> 1;
                    stage <= stage_nx;
                    carry <= carry_nx;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST_BIT) begin
                        y_q   <= result;
                        ovf_q <= ovf_pend;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.Y    = y_q;
    assign bus.ovf  = ovf_q;
endmodule
